hash_pe_dispatch_scheduler: RTL and testbench

Parametrised successor to the hash-engine pre-scheduler. Each input beat carries ISSUE_W hash values, and each value is steered to one of NUM_PE hash PEs by its top hash bits. The block buffers up to BEAT_DEPTH beats so input can keep flowing while earlier beats drain. Bank conflicts inside a beat are serialised into several output beats, and the per-PE lane count can be capped with a runtime drop limit. It sits between the hash-compute stage and the hash PE array.

---
 rtl/hash_sched_pkg.sv | 17 +
 rtl/hash_sched_lane_picker.sv | 20 ++
 rtl/hash_pe_dispatch_scheduler.sv | 179 +++++++++++++++++
 tb/tb_hash_pe_dispatch_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_sched_pkg.sv
// Shared helpers for the hash PE dispatch scheduler: index-width functions and the per-lane cap filter.
package hash_sched_pkg;

  function automatic int pe_log2(input int num_pe);
    return $clog2(num_pe);
  endfunction

  function automatic int lane_log2(input int issue_w);
    return $clog2(issue_w);
  endfunction

  // A lane whose rank among same-PE lanes of its beat is below the cap survives; cap 0 keeps all.
  function automatic logic cap_keep(input int unsigned rank, input int unsigned cap);
    return (cap == 0) || (rank < cap);
  endfunction

endpackage

// File: rtl/hash_sched_lane_picker.sv
// Priority encoder for one PE: reports whether any lane is pending and the lowest pending lane index.
module hash_sched_lane_picker #(
  parameter int W = 16
) (
  input  logic [W-1:0]         req,
  output logic                 found,
  output logic [$clog2(W)-1:0] lane
);
  localparam int LW = $clog2(W);

  assign found = |req;

  always_comb begin
    lane = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) lane = LW'(i);
    end
  end

endmodule

// File: rtl/hash_pe_dispatch_scheduler.sv
// Steers ISSUE_W hashes/beat to NUM_PE banks, serialising conflicts; 2-cycle latency, input_ready drops when
// the BEAT_DEPTH queue is full, output holds while output_ready=0. HASH_SCHED_STATS_EN adds drop/stall counters.
module hash_pe_dispatch_scheduler
  import hash_sched_pkg::*;
#(
  parameter int ISSUE_W    = 16,
  parameter int NUM_PE     = 16,
  parameter int HASH_BITS  = 15,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 248,
  parameter int BEAT_DEPTH = 2
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [$clog2(ISSUE_W):0]                      cfg_max_lanes_per_pe,
  input  logic                                          input_valid,
  input  logic [ADDR_W-1:0]                             input_head_addr,
  input  logic [HASH_BITS*ISSUE_W-1:0]                  input_hash_value_vec,
  input  logic [DATA_W-1:0]                             input_data,
  input  logic                                          input_delim,
  output logic                                          input_ready,
  output logic                                          output_valid,
  output logic [NUM_PE-1:0]                             output_mask,
  output logic [NUM_PE*ADDR_W-1:0]                      output_addr,
  output logic [NUM_PE*(HASH_BITS-$clog2(NUM_PE))-1:0]  output_hash_value,
  output logic [DATA_W-1:0]                             output_data,
  output logic                                          output_delim,
`ifdef HASH_SCHED_STATS_EN
  output logic [31:0]                                   stat_drop_cnt,
  output logic [31:0]                                   stat_stall_cnt,
`endif
  input  logic                                          output_ready
);
  localparam int PL = pe_log2(NUM_PE);
  localparam int LL = lane_log2(ISSUE_W);
  localparam int LH = HASH_BITS - PL;
  localparam int PW = $clog2(BEAT_DEPTH);
  localparam int NP = NUM_PE * ISSUE_W;
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(ISSUE_W - 1);

  typedef struct packed {
    logic [ADDR_W-1:0]     head_addr;
    logic [LH*ISSUE_W-1:0] hash_vec;
    logic [DATA_W-1:0]     data;
    logic                  delim;
  } beat_slot_t;

  beat_slot_t    slot_q [BEAT_DEPTH];
  logic [NP-1:0] pend_q [BEAT_DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr;
  logic [PW-1:0] wr_idx, rd_idx;
  logic          full, wr_en;

  assign wr_idx      = wr_ptr[PW-1:0];
  assign rd_idx      = rd_ptr[PW-1:0];
  assign full        = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
  assign input_ready = ~full;
  assign wr_en       = input_valid & ~full;

  logic [PL-1:0]         lane_pe [ISSUE_W];
  logic [LH*ISSUE_W-1:0] local_vec;

  for (genvar l = 0; l < ISSUE_W; l++) begin : g_lane
    assign lane_pe[l]                = input_hash_value_vec[l*HASH_BITS + HASH_BITS - 1 -: PL];
    assign local_vec[l*LH +: LH]     = input_hash_value_vec[l*HASH_BITS +: LH];
  end

  // Rank each lane among earlier lanes bound for the same PE, then apply the cap.
  logic [NP-1:0] pend_in;
  always_comb begin
    int unsigned rank;
    pend_in = '0;
    rank    = 0;
    for (int l = 0; l < ISSUE_W; l++) begin
      rank = 0;
      for (int k = 0; k < l; k++) begin
        if (lane_pe[k] == lane_pe[l]) rank++;
      end
      if (cap_keep(rank, 32'(cfg_max_lanes_per_pe)))
        pend_in[int'(lane_pe[l])*ISSUE_W + l] = 1'b1;
    end
  end

  beat_slot_t        head;
  logic [NP-1:0]     head_pend, clr, pend_left;
  logic [NUM_PE-1:0] found;
  logic [LL-1:0]     pick [NUM_PE];
  logic              head_has, load, retire;

  assign head      = slot_q[rd_idx];
  assign head_pend = pend_q[rd_idx];

  for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
    hash_sched_lane_picker #(.W(ISSUE_W)) u_picker (
      .req   (head_pend[p*ISSUE_W +: ISSUE_W]),
      .found (found[p]),
      .lane  (pick[p])
    );
  end

  logic [NUM_PE*ADDR_W-1:0] addr_nxt;
  logic [NUM_PE*LH-1:0]     hash_nxt;
  always_comb begin
    clr      = '0;
    addr_nxt = '0;
    hash_nxt = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      if (found[p]) clr[p*ISSUE_W + int'(pick[p])] = 1'b1;
      addr_nxt[p*ADDR_W +: ADDR_W] = (head.head_addr & ~LANE_MASK) | ADDR_W'(pick[p]);
      hash_nxt[p*LH +: LH]         = head.hash_vec[int'(pick[p])*LH +: LH];
    end
  end

  // Empty slots always hold an all-zero pending matrix, so no separate empty check is needed.
  assign head_has  = |head_pend;
  assign load      = head_has & (~output_valid | output_ready);
  assign pend_left = head_pend & ~clr;
  assign retire    = load & ~|pend_left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int d = 0; d < BEAT_DEPTH; d++) pend_q[d] <= '0;
    end else begin
      if (load) pend_q[rd_idx] <= pend_left;
      if (wr_en) begin
        pend_q[wr_idx] <= pend_in;
        wr_ptr         <= wr_ptr + (PW+1)'(1);
      end
      if (retire) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) slot_q[wr_idx] <= '{input_head_addr, local_vec, input_data, input_delim};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_valid <= 1'b0;
      output_mask  <= '0;
      output_delim <= 1'b0;
    end else if (load) begin
      output_valid <= 1'b1;
      output_mask  <= found;
      output_delim <= retire & head.delim;
    end else if (output_ready) begin
      output_valid <= 1'b0;
      output_mask  <= '0;
      output_delim <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      output_addr       <= addr_nxt;
      output_hash_value <= hash_nxt;
      output_data       <= head.data;
    end
  end

`ifdef HASH_SCHED_STATS_EN
  logic [32:0] drop_sum;
  assign drop_sum = {1'b0, stat_drop_cnt} + 33'(ISSUE_W - $countones(pend_in));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_drop_cnt  <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (wr_en) stat_drop_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
      if (output_valid && !output_ready && (stat_stall_cnt != '1))
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hash_pe_dispatch_scheduler.sv
// Directed bench for hash_pe_dispatch_scheduler at the default configuration.
module tb_hash_pe_dispatch_scheduler;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   cfg;
  logic         in_valid;
  logic [31:0]  in_addr;
  logic [239:0] in_hash;
  logic [247:0] in_data;
  logic         in_delim;
  logic         in_ready;
  logic         out_valid;
  logic [15:0]  out_mask;
  logic [511:0] out_addr;
  logic [175:0] out_hash;
  logic [247:0] out_data;
  logic         out_delim;
  logic         out_ready;
`ifdef HASH_SCHED_STATS_EN
  logic [31:0]  stat_drop;
  logic [31:0]  stat_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hash_pe_dispatch_scheduler dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cfg_max_lanes_per_pe (cfg),
    .input_valid          (in_valid),
    .input_head_addr      (in_addr),
    .input_hash_value_vec (in_hash),
    .input_data           (in_data),
    .input_delim          (in_delim),
    .input_ready          (in_ready),
    .output_valid         (out_valid),
    .output_mask          (out_mask),
    .output_addr          (out_addr),
    .output_hash_value    (out_hash),
    .output_data          (out_data),
    .output_delim         (out_delim),
`ifdef HASH_SCHED_STATS_EN
    .stat_drop_cnt        (stat_drop),
    .stat_stall_cnt       (stat_stall),
`endif
    .output_ready         (out_ready)
  );

  logic [15:0]  mon_mask  [$];
  logic [511:0] mon_addr  [$];
  logic [175:0] mon_hash  [$];
  logic [247:0] mon_data  [$];
  logic         mon_delim [$];
  int           mon_cyc   [$];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_mask.push_back(out_mask);
      mon_addr.push_back(out_addr);
      mon_hash.push_back(out_hash);
      mon_data.push_back(out_data);
      mon_delim.push_back(out_delim);
      mon_cyc.push_back(cyc);
    end
  end

  function automatic logic [247:0] data_of(input logic [7:0] tag);
    return {31{tag}};
  endfunction

  // Lane i goes to PE i with bank-local hash base + step*i.
  function automatic logic [239:0] hv_distinct(input int base, input int step);
    logic [239:0] hv;
    for (int i = 0; i < 16; i++) hv[i*15 +: 15] = {4'(i), 11'(base + step*i)};
    return hv;
  endfunction

  // Every lane goes to one PE with bank-local hash equal to its lane index.
  function automatic logic [239:0] hv_same(input logic [3:0] pe);
    logic [239:0] hv;
    for (int i = 0; i < 16; i++) hv[i*15 +: 15] = {pe, 11'(i)};
    return hv;
  endfunction

  task automatic clear_mon;
    mon_mask.delete(); mon_addr.delete(); mon_hash.delete();
    mon_data.delete(); mon_delim.delete(); mon_cyc.delete();
  endtask

  // Entered and left at one time unit after a rising edge; returns just after the handshake edge.
  task automatic send_beat(input logic [31:0] addr, input logic [239:0] hv, input logic [7:0] tag, input logic delim);
    logic fire;
    int   n;
    in_valid = 1'b1; in_addr = addr; in_hash = hv; in_data = data_of(tag); in_delim = delim;
    fire = 1'b0; n = 0;
    while (!fire && n < 50) begin
      fire = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!fire) begin
      n_fail++;
      $display("FAIL send_beat handshake: input_ready=%b after %0d cycles, required 1", in_ready, n);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cfg = '0; in_valid = 1'b0; in_addr = '0; in_hash = '0; in_data = '0;
    in_delim = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    n_checks++; if (out_mask !== 16'h0) begin n_fail++; $display("FAIL reset_mask: got %h required 0000", out_mask); end
    n_checks++; if (out_delim !== 1'b0) begin n_fail++; $display("FAIL reset_delim: got %b required 0", out_delim); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_distinct;
    clear_mon(); cfg = 5'd0;
    send_beat(32'h1000, hv_distinct(32, 1), 8'hA1, 1'b1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL distinct_t1_valid: got %b required 0", out_valid); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL distinct_t2_valid: got %b required 1", out_valid); end
    n_checks++; if (out_mask !== 16'hFFFF) begin n_fail++; $display("FAIL distinct_mask: got %h required ffff", out_mask); end
    n_checks++; if (out_delim !== 1'b1) begin n_fail++; $display("FAIL distinct_delim: got %b required 1", out_delim); end
    n_checks++; if (out_data !== data_of(8'hA1)) begin n_fail++; $display("FAIL distinct_data: got %h required %h", out_data, data_of(8'hA1)); end
    for (int pe = 0; pe < 16; pe++) begin
      n_checks++;
      if (out_addr[pe*32 +: 32] !== 32'h1000 + 32'(pe)) begin
        n_fail++; $display("FAIL distinct_addr[%0d]: got %h required %h", pe, out_addr[pe*32 +: 32], 32'h1000 + 32'(pe));
      end
      n_checks++;
      if (out_hash[pe*11 +: 11] !== 11'(32 + pe)) begin
        n_fail++; $display("FAIL distinct_hash[%0d]: got %h required %h", pe, out_hash[pe*11 +: 11], 11'(32 + pe));
      end
    end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL distinct_single_beat: valid=%b required 0", out_valid); end
  endtask

  task automatic test_conflict(input logic [4:0] cap, input int nexp, input logic [7:0] tag);
    clear_mon(); cfg = cap;
    send_beat(32'h1000, hv_same(4'd3), tag, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (mon_mask.size() !== nexp) begin
      n_fail++; $display("FAIL conflict_cap%0d_beats: got %0d required %0d", cap, mon_mask.size(), nexp);
    end
    for (int k = 0; k < nexp && k < mon_mask.size(); k++) begin
      n_checks++;
      if (mon_mask[k] !== 16'h0008) begin n_fail++; $display("FAIL conflict_cap%0d_mask[%0d]: got %h required 0008", cap, k, mon_mask[k]); end
      n_checks++;
      if (mon_addr[k][3*32 +: 32] !== 32'h1000 + 32'(k)) begin
        n_fail++; $display("FAIL conflict_cap%0d_addr[%0d]: got %h required %h", cap, k, mon_addr[k][3*32 +: 32], 32'h1000 + 32'(k));
      end
      n_checks++;
      if (mon_hash[k][3*11 +: 11] !== 11'(k)) begin
        n_fail++; $display("FAIL conflict_cap%0d_hash[%0d]: got %h required %h", cap, k, mon_hash[k][3*11 +: 11], 11'(k));
      end
      n_checks++;
      if (mon_delim[k] !== (k == nexp - 1)) begin
        n_fail++; $display("FAIL conflict_cap%0d_delim[%0d]: got %b required %b", cap, k, mon_delim[k], (k == nexp - 1));
      end
      n_checks++;
      if (mon_data[k] !== data_of(tag)) begin n_fail++; $display("FAIL conflict_cap%0d_data[%0d]: got %h required %h", cap, k, mon_data[k], data_of(tag)); end
    end
`ifdef HASH_SCHED_STATS_EN
    if (cap == 5'd4) begin
      n_checks++;
      if (stat_drop !== 32'd12) begin n_fail++; $display("FAIL stat_drop: got %0d required 12", stat_drop); end
    end
`endif
    cfg = 5'd0;
  endtask

  task automatic test_backpressure;
    int k, unstable;
    logic fire, have;
    logic [511:0] snap_addr;
    logic [247:0] snap_data;
    logic [15:0]  snap_mask;
    clear_mon(); cfg = 5'd0; out_ready = 1'b0;
    k = 0; unstable = 0; have = 1'b0; snap_addr = '0; snap_data = '0; snap_mask = '0;
    for (int c = 0; c < 70; c++) begin
      if (c == 10) begin
        n_checks++; if (k !== 3) begin n_fail++; $display("FAIL bp_accepts: got %0d required 3", k); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b required 0", in_ready); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b required 1", out_valid); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes required 0", unstable); end
        n_checks++;
        if (out_addr[31:0] !== 32'h2000) begin n_fail++; $display("FAIL bp_held_addr: got %h required 00002000", out_addr[31:0]); end
        out_ready = 1'b1;
      end
      in_valid = (k < 5);
      in_addr  = 32'h2000 + 32'(k*16);
      in_hash  = hv_distinct(k, 0);
      in_data  = data_of(8'hC0 + 8'(k));
      in_delim = k[0];
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) k++;
      if (!out_ready && out_valid) begin
        if (!have) begin
          have = 1'b1; snap_addr = out_addr; snap_data = out_data; snap_mask = out_mask;
        end else if (out_addr !== snap_addr || out_data !== snap_data || out_mask !== snap_mask) begin
          unstable++;
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (mon_mask.size() !== 5) begin n_fail++; $display("FAIL bp_beats: got %0d required 5", mon_mask.size()); end
    for (int j = 0; j < 5 && j < mon_mask.size(); j++) begin
      n_checks++;
      if (mon_addr[j][31:0] !== 32'h2000 + 32'(j*16)) begin
        n_fail++; $display("FAIL bp_order_addr[%0d]: got %h required %h", j, mon_addr[j][31:0], 32'h2000 + 32'(j*16));
      end
      n_checks++;
      if (mon_hash[j][10:0] !== 11'(j)) begin n_fail++; $display("FAIL bp_hash[%0d]: got %h required %h", j, mon_hash[j][10:0], 11'(j)); end
      n_checks++;
      if (mon_mask[j] !== 16'hFFFF) begin n_fail++; $display("FAIL bp_mask[%0d]: got %h required ffff", j, mon_mask[j]); end
      n_checks++;
      if (mon_delim[j] !== 1'(j % 2)) begin n_fail++; $display("FAIL bp_delim[%0d]: got %b required %b", j, mon_delim[j], 1'(j % 2)); end
    end
  endtask

  task automatic test_back_to_back;
    logic [239:0] hv_a;
    logic [15:0]  exp_mask [3];
    logic [31:0]  exp_addr [3];
    logic [7:0]   exp_tag  [3];
    clear_mon(); cfg = 5'd0; out_ready = 1'b1;
    hv_a = hv_distinct(0, 1);
    hv_a[1*15 +: 15] = {4'd0, 11'd1};
    exp_mask = '{16'hFFFD, 16'h0001, 16'hFFFF};
    exp_addr = '{32'h3000, 32'h3001, 32'h3010};
    exp_tag  = '{8'hD1, 8'hD1, 8'hD2};
    send_beat(32'h3000, hv_a, 8'hD1, 1'b0);
    send_beat(32'h3010, hv_distinct(0, 1), 8'hD2, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (mon_mask.size() !== 3) begin n_fail++; $display("FAIL b2b_beats: got %0d required 3", mon_mask.size()); end
    for (int j = 0; j < 3 && j < mon_mask.size(); j++) begin
      n_checks++;
      if (mon_mask[j] !== exp_mask[j]) begin n_fail++; $display("FAIL b2b_mask[%0d]: got %h required %h", j, mon_mask[j], exp_mask[j]); end
      n_checks++;
      if (mon_addr[j][31:0] !== exp_addr[j]) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %h required %h", j, mon_addr[j][31:0], exp_addr[j]); end
      n_checks++;
      if (mon_data[j] !== data_of(exp_tag[j])) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h required %h", j, mon_data[j][7:0], exp_tag[j]); end
      n_checks++;
      if (mon_delim[j] !== (j == 2)) begin n_fail++; $display("FAIL b2b_delim[%0d]: got %b required %b", j, mon_delim[j], (j == 2)); end
      if (j > 0) begin
        n_checks++;
        if (mon_cyc[j] !== mon_cyc[j-1] + 1) begin
          n_fail++; $display("FAIL b2b_no_bubble[%0d]: cycle %0d required %0d", j, mon_cyc[j], mon_cyc[j-1] + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_drain;
    clear_mon(); cfg = 5'd0; out_ready = 1'b1;
    send_beat(32'h1000, hv_same(4'd3), 8'hE1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_drain_active: got %b required 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b required 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b required 1", in_ready); end
    n_checks++; if (out_mask !== 16'h0) begin n_fail++; $display("FAIL mid_reset_mask: got %h required 0000", out_mask); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (mon_mask.size() !== 0) begin n_fail++; $display("FAIL post_reset_residual: got %0d beats required 0", mon_mask.size()); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b required 0", out_valid); end
    send_beat(32'h4000, hv_distinct(7, 0), 8'hF1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (mon_mask.size() !== 1) begin n_fail++; $display("FAIL recovery_beats: got %0d required 1", mon_mask.size()); end
    if (mon_addr.size() > 0) begin
      n_checks++;
      if (mon_addr[0][5*32 +: 32] !== 32'h4005) begin n_fail++; $display("FAIL recovery_addr: got %h required 00004005", mon_addr[0][5*32 +: 32]); end
    end
  endtask

  initial begin
    test_reset();
    test_distinct();
    test_conflict(5'd0, 16, 8'hB0);
    test_conflict(5'd4, 4, 8'hB4);
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
